// File: rtl/layer_compositor_if.sv
// Pixel-side bundle of the layer compositor: per-layer requests in, composited pixel and
// per-frame collision report out.
interface layer_compositor_if #(
    parameter int unsigned NUM_LAYERS = 11,
    parameter int unsigned COLOR_W    = 8
);
    localparam int unsigned IdxW = $clog2(NUM_LAYERS);

    logic                          startOfFrame;
    logic [NUM_LAYERS-1:0]         layerEnable;
    logic [NUM_LAYERS-1:0]         layerDR;
    logic [NUM_LAYERS*COLOR_W-1:0] layerRGB;
    logic [COLOR_W-1:0]            RGBOut;
    logic [IdxW-1:0]               winLayer;
    logic                          winValid;
    logic [NUM_LAYERS-1:0]         collisionFlags;
    logic                          collisionValid;

    modport master (
        output startOfFrame, layerEnable, layerDR, layerRGB,
        input  RGBOut, winLayer, winValid, collisionFlags, collisionValid
    );

    modport slave (
        input  startOfFrame, layerEnable, layerDR, layerRGB,
        output RGBOut, winLayer, winValid, collisionFlags, collisionValid
    );
endinterface

// File: rtl/layer_compositor.sv
// N-layer priority pixel compositor with colour-key transparency, two-stage output pipeline
// and per-frame overlap flags between layer 0 and every other layer.
module layer_compositor #(
    parameter int unsigned        NUM_LAYERS        = 11,
    parameter int unsigned        COLOR_W           = 8,
    parameter bit                 TRANSPARENT_EN    = 1'b1,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = {COLOR_W{1'b1}},
    parameter logic [COLOR_W-1:0] BACKGROUND_COLOR  = '0
) (
    input logic               clk,
    input logic               resetN,
    layer_compositor_if.slave pix
);
    localparam int unsigned IdxW = $clog2(NUM_LAYERS);

    logic [NUM_LAYERS-1:0] eff;
    logic [NUM_LAYERS-1:0] hits;
    logic [IdxW-1:0]       win_idx;
    logic [COLOR_W-1:0]    win_rgb;
    logic                  win_vld;

    logic [IdxW-1:0]       s1_idx_q;
    logic [COLOR_W-1:0]    s1_rgb_q;
    logic                  s1_vld_q;
    logic [IdxW-1:0]       out_idx_q;
    logic [COLOR_W-1:0]    out_rgb_q;
    logic                  out_vld_q;

    logic [NUM_LAYERS-1:0] acc_d, acc_q;
    logic [NUM_LAYERS-1:0] flags_d, flags_q;
    logic                  cvalid_d, cvalid_q;

    always_comb begin
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            eff[i] = pix.layerDR[i] & pix.layerEnable[i] &
                     !(TRANSPARENT_EN && (pix.layerRGB[i*COLOR_W +: COLOR_W] == TRANSPARENT_COLOR));
        end
    end

    // Scan from the lowest priority upwards so the lowest set index is the last one written.
    always_comb begin
        win_idx = '0;
        win_rgb = BACKGROUND_COLOR;
        win_vld = 1'b0;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (eff[i]) begin
                win_idx = IdxW'(i);
                win_rgb = pix.layerRGB[i*COLOR_W +: COLOR_W];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        hits    = eff & {NUM_LAYERS{eff[0]}};
        hits[0] = 1'b0;
    end

    // The frame-closing cycle's own overlaps belong to the frame being reported.
    always_comb begin
        acc_d    = acc_q | hits;
        flags_d  = flags_q;
        cvalid_d = 1'b0;
        if (pix.startOfFrame) begin
            flags_d  = acc_q | hits;
            acc_d    = '0;
            cvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            s1_idx_q  <= '0;
            s1_rgb_q  <= BACKGROUND_COLOR;
            s1_vld_q  <= 1'b0;
            out_idx_q <= '0;
            out_rgb_q <= BACKGROUND_COLOR;
            out_vld_q <= 1'b0;
            acc_q     <= '0;
            flags_q   <= '0;
            cvalid_q  <= 1'b0;
        end else begin
            s1_idx_q  <= win_idx;
            s1_rgb_q  <= win_rgb;
            s1_vld_q  <= win_vld;
            out_idx_q <= s1_idx_q;
            out_rgb_q <= s1_rgb_q;
            out_vld_q <= s1_vld_q;
            acc_q     <= acc_d;
            flags_q   <= flags_d;
            cvalid_q  <= cvalid_d;
        end
    end

    assign pix.RGBOut         = out_rgb_q;
    assign pix.winLayer       = out_idx_q;
    assign pix.winValid       = out_vld_q;
    assign pix.collisionFlags = flags_q;
    assign pix.collisionValid = cvalid_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: vector table on the default build and a colour-key-off build,
// hand sequences for frame/collision/reset corners, random sweep on a 4-layer 12-bit build.
module tb_layer_compositor;
    logic clk;
    logic resetN;
    int   total;
    int   bad;

    layer_compositor_if #(.NUM_LAYERS(11), .COLOR_W(8))  a_if ();
    layer_compositor_if #(.NUM_LAYERS(11), .COLOR_W(8))  b_if ();
    layer_compositor_if #(.NUM_LAYERS(4),  .COLOR_W(12)) c_if ();

    layer_compositor u_a (
        .clk    (clk),
        .resetN (resetN),
        .pix    (a_if)
    );

    layer_compositor #(
        .TRANSPARENT_EN (1'b0)
    ) u_b (
        .clk    (clk),
        .resetN (resetN),
        .pix    (b_if)
    );

    layer_compositor #(
        .NUM_LAYERS       (4),
        .COLOR_W          (12),
        .TRANSPARENT_COLOR(12'hFFF),
        .BACKGROUND_COLOR (12'h123)
    ) u_c (
        .clk    (clk),
        .resetN (resetN),
        .pix    (c_if)
    );

    // The key-off build always sees the same pixels as the default build.
    assign b_if.startOfFrame = a_if.startOfFrame;
    assign b_if.layerEnable  = a_if.layerEnable;
    assign b_if.layerDR      = a_if.layerDR;
    assign b_if.layerRGB     = a_if.layerRGB;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] en;
        logic [10:0] dr;
        logic [87:0] rgb;
        logic [7:0]  a_rgb;
        logic [3:0]  a_idx;
        logic        a_vld;
        logic [7:0]  b_rgb;
        logic [3:0]  b_idx;
        logic        b_vld;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic logic [87:0] set_l(input logic [87:0] r, input int l, input logic [7:0] c);
        logic [87:0] t;
        t = r;
        t[l*8 +: 8] = c;
        return t;
    endfunction

    function automatic vec_t mk(input logic [10:0] en, input logic [10:0] dr, input logic [87:0] rgb,
                                input logic [7:0] ar, input logic [3:0] ai, input logic av,
                                input logic [7:0] br, input logic [3:0] bi, input logic bv);
        vec_t v;
        v.en = en; v.dr = dr; v.rgb = rgb;
        v.a_rgb = ar; v.a_idx = ai; v.a_vld = av;
        v.b_rgb = br; v.b_idx = bi; v.b_vld = bv;
        return v;
    endfunction

    task automatic idle_inputs();
        a_if.startOfFrame = 1'b0;
        a_if.layerEnable  = '1;
        a_if.layerDR      = '0;
        a_if.layerRGB     = '0;
        c_if.startOfFrame = 1'b0;
        c_if.layerEnable  = '0;
        c_if.layerDR      = '0;
        c_if.layerRGB     = '0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Apply one cycle of stimulus to the default build and move to the next falling edge.
    task automatic px(input logic [10:0] dr, input logic [87:0] rgb, input logic sof);
        a_if.layerDR      = dr;
        a_if.layerRGB     = rgb;
        a_if.startOfFrame = sof;
        @(negedge clk);
    endtask

    task automatic chk_col(input string nm, input logic [10:0] flags, input logic cv);
        chk({nm, "_flags"}, 32'(a_if.collisionFlags), 32'(flags));
        chk({nm, "_cvalid"}, 32'(a_if.collisionValid), 32'(cv));
    endtask

    initial begin
        logic [87:0] rc;
        logic [87:0] rff;
        logic [14:0] pq[$];
        logic [14:0] pe;
        logic [3:0]  dr, en, e, hits, m_acc, m_flags;
        logic        m_cv, sof, found;
        logic [47:0] r;
        logic [1:0]  ei;
        logic [11:0] er;

        total = 0;
        bad   = 0;
        idle_inputs();
        do_reset();
        @(negedge clk);

        chk("rst_rgb",    32'(a_if.RGBOut), 32'h00);
        chk("rst_layer",  32'(a_if.winLayer), 32'h0);
        chk("rst_valid",  32'(a_if.winValid), 32'h0);
        chk_col("rst", 11'h000, 1'b0);
        chk("rst_c_rgb",  32'(c_if.RGBOut), 32'h123);

        // Directed priority / key / enable vectors.
        rff = '1;
        vecs.push_back(mk(11'h7FF, 11'h006, set_l(set_l('0, 1, 8'h1C), 2, 8'hE0),
                          8'h1C, 4'd1, 1'b1, 8'h1C, 4'd1, 1'b1));
        vecs.push_back(mk(11'h7FF, 11'h201, set_l(set_l('0, 0, 8'hFF), 9, 8'h92),
                          8'h92, 4'd9, 1'b1, 8'hFF, 4'd0, 1'b1));
        vecs.push_back(mk(11'h5FF, 11'h201, set_l(set_l('0, 0, 8'hFF), 9, 8'h92),
                          8'h00, 4'd0, 1'b0, 8'hFF, 4'd0, 1'b1));
        vecs.push_back(mk(11'h7FF, 11'h000, set_l('0, 4, 8'h77),
                          8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(11'h000, 11'h7FF, set_l('0, 0, 8'h12),
                          8'h00, 4'd0, 1'b0, 8'h00, 4'd0, 1'b0));
        vecs.push_back(mk(11'h7FF, 11'h400, set_l('0, 10, 8'h55),
                          8'h55, 4'd10, 1'b1, 8'h55, 4'd10, 1'b1));
        vecs.push_back(mk(11'h7F7, 11'h018, set_l(set_l('0, 3, 8'h11), 4, 8'h22),
                          8'h22, 4'd4, 1'b1, 8'h22, 4'd4, 1'b1));
        vecs.push_back(mk(11'h7FF, 11'h001, '0,
                          8'h00, 4'd0, 1'b1, 8'h00, 4'd0, 1'b1));
        vecs.push_back(mk(11'h7FF, 11'h7FF, set_l(rff, 7, 8'h3C),
                          8'h3C, 4'd7, 1'b1, 8'hFF, 4'd0, 1'b1));

        foreach (vecs[k]) begin
            a_if.layerEnable = vecs[k].en;
            a_if.layerDR     = vecs[k].dr;
            a_if.layerRGB    = vecs[k].rgb;
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_a_rgb", k),   32'(a_if.RGBOut),   32'(vecs[k].a_rgb));
            chk($sformatf("vec%0d_a_layer", k), 32'(a_if.winLayer), 32'(vecs[k].a_idx));
            chk($sformatf("vec%0d_a_valid", k), 32'(a_if.winValid), 32'(vecs[k].a_vld));
            chk($sformatf("vec%0d_b_rgb", k),   32'(b_if.RGBOut),   32'(vecs[k].b_rgb));
            chk($sformatf("vec%0d_b_layer", k), 32'(b_if.winLayer), 32'(vecs[k].b_idx));
            chk($sformatf("vec%0d_b_valid", k), 32'(b_if.winValid), 32'(vecs[k].b_vld));
        end

        // Exact two-edge latency, both on the way in and on the way out.
        a_if.layerEnable = '1;
        px(11'h000, '0, 1'b0);
        px(11'h000, '0, 1'b0);
        px(11'h006, set_l(set_l('0, 1, 8'h1C), 2, 8'hE0), 1'b0);
        chk("lat_in_1edge", 32'(a_if.RGBOut), 32'h00);
        px(11'h000, '0, 1'b0);
        chk("lat_in_2edge", 32'(a_if.RGBOut), 32'h1C);
        px(11'h000, '0, 1'b0);
        chk("lat_out_1edge", 32'(a_if.RGBOut), 32'h00);

        // Collision accumulation over one frame.
        do_reset();
        rc = '0;
        for (int l = 0; l < 11; l++) rc = set_l(rc, l, (l == 0) ? 8'h10 : 8'h20);
        for (int n = 0; n < 4; n++) px(11'h009, rc, 1'b0);
        px(11'h081, rc, 1'b0);
        a_if.layerEnable = 11'h7DF;
        px(11'h021, rc, 1'b0);
        a_if.layerEnable = '1;
        px(11'h041, set_l(rc, 0, 8'hFF), 1'b0);
        px(11'h006, rc, 1'b0);
        px(11'h000, rc, 1'b1);
        chk_col("frame1", 11'h088, 1'b1);
        px(11'h000, rc, 1'b0);
        chk_col("frame1_hold", 11'h088, 1'b0);
        px(11'h000, rc, 1'b0);
        px(11'h000, rc, 1'b1);
        chk_col("frame2_empty", 11'h000, 1'b1);

        // Overlap seen only in the frame-closing cycle.
        px(11'h021, rc, 1'b1);
        chk_col("sof_same_cycle", 11'h020, 1'b1);
        px(11'h000, rc, 1'b0);
        px(11'h000, rc, 1'b1);
        chk_col("sof_next_frame", 11'h000, 1'b1);

        // Back-to-back frame pulses.
        px(11'h009, rc, 1'b1);
        chk_col("b2b_first", 11'h008, 1'b1);
        px(11'h041, rc, 1'b1);
        chk_col("b2b_second", 11'h040, 1'b1);
        px(11'h000, rc, 1'b0);
        chk_col("b2b_after", 11'h040, 1'b0);

        // Reset mid-frame drops the accumulator and flushes the pipeline.
        px(11'h005, rc, 1'b0);
        px(11'h005, rc, 1'b0);
        chk("pre_reset_rgb", 32'(a_if.RGBOut), 32'h10);
        resetN = 1'b0;
        px(11'h005, rc, 1'b0);
        chk("in_reset_rgb",   32'(a_if.RGBOut), 32'h00);
        chk("in_reset_valid", 32'(a_if.winValid), 32'h0);
        chk_col("in_reset", 11'h000, 1'b0);
        resetN = 1'b1;
        px(11'h001, rc, 1'b0);
        chk("rel_1edge_rgb", 32'(a_if.RGBOut), 32'h00);
        px(11'h001, rc, 1'b0);
        chk("rel_2edge_rgb",   32'(a_if.RGBOut), 32'h10);
        chk("rel_2edge_valid", 32'(a_if.winValid), 32'h1);
        px(11'h000, rc, 1'b1);
        chk_col("rel_sof", 11'h000, 1'b1);

        // Random sweep on the 4-layer build against a priority/frame model.
        do_reset();
        m_acc = '0;
        m_flags = '0;
        m_cv = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            chk("sweep_flags",  32'(c_if.collisionFlags), 32'(m_flags));
            chk("sweep_cvalid", 32'(c_if.collisionValid), 32'(m_cv));
            if (pq.size() == 2) begin
                pe = pq.pop_front();
                chk("sweep_pix", 32'({c_if.winValid, c_if.winLayer, c_if.RGBOut}), 32'(pe));
            end

            dr  = 4'($urandom);
            en  = 4'($urandom) | 4'($urandom);
            sof = ($urandom_range(0, 15) == 0);
            for (int l = 0; l < 4; l++)
                r[l*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            c_if.layerDR      = dr;
            c_if.layerEnable  = en;
            c_if.layerRGB     = r;
            c_if.startOfFrame = sof;

            for (int l = 0; l < 4; l++) e[l] = dr[l] & en[l] & (r[l*12 +: 12] != 12'hFFF);
            found = 1'b0;
            ei = '0;
            er = 12'h123;
            for (int l = 0; l < 4; l++) begin
                if (e[l] && !found) begin
                    found = 1'b1;
                    ei = 2'(l);
                    er = r[l*12 +: 12];
                end
            end
            pq.push_back({found, ei, er});

            hits = e[0] ? (e & 4'b1110) : 4'b0000;
            if (sof) begin
                m_flags = m_acc | hits;
                m_acc   = '0;
                m_cv    = 1'b1;
            end else begin
                m_acc = m_acc | hits;
                m_cv  = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised N-layer priority pixel compositor for the billiard VGA pipeline; sits between the object drawers (balls, hole number, holes, borders, board) and the VGA controller.
- Selects the highest-priority active layer per pixel, with an optional transparent colour key and per-layer enable mask.
- Pipelines the result over two fixed cycles.
- Accumulates per-frame overlap flags between layer 0 (the cue/white ball) and every other layer, for the game logic to use as collision events.

Parameters:
- NUM_LAYERS, 11, number of input layers; index 0 is highest priority; must be >= 2.
- COLOR_W, 8, pixel colour width in bits.
- TRANSPARENT_EN, 1, 1 = a pixel equal to TRANSPARENT_COLOR is treated as not drawn.
- TRANSPARENT_COLOR, 8'hFF, colour key; width COLOR_W.
- BACKGROUND_COLOR, 0, output colour when no layer wins; width COLOR_W.

Ports:
- clk, input, 1, system clock.
- resetN, input, 1, reset; synchronous, active-low.
- startOfFrame, input, 1, one-cycle pulse marking frame boundary.
- layerEnable, input, NUM_LAYERS, per-layer enable mask.
- layerDR, input, NUM_LAYERS, per-layer drawing request.
- layerRGB, input, NUM_LAYERS*COLOR_W, packed colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- RGBOut, output, COLOR_W, composited pixel.
- winLayer, output, $clog2(NUM_LAYERS), index of the winning layer (0 when none).
- winValid, output, 1, 1 when some layer won this pixel.
- collisionFlags, output, NUM_LAYERS, bit i = layer 0 overlapped layer i during the last completed frame; bit 0 is always 0.
- collisionValid, output, 1, one-cycle pulse when collisionFlags updates.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-low: all registers are sampled on posedge clk while resetN==0.
- Reset values:
  - RGBOut = BACKGROUND_COLOR.
  - winLayer = 0, winValid = 0.
  - collisionFlags = 0, collisionValid = 0.
  - Internal collision accumulator = 0.
  - Both pipeline stages are cleared.
- Effective request, per layer i:
  - eff[i] = layerDR[i] & layerEnable[i] & !(TRANSPARENT_EN && layerRGB[i] == TRANSPARENT_COLOR).
  - With TRANSPARENT_EN=0 the key comparison is ignored.
- Priority: the lowest index i with eff[i]=1 wins. If no bit is set, the output is BACKGROUND_COLOR, winValid=0 and winLayer=0.
- Pipeline (fixed latency 2 cycles, no stalls, no bubbles):
  - Stage 1 registers the winner index, winner colour and winValid.
  - Stage 2 registers RGBOut, winLayer and winValid.
  - Inputs sampled at edge k appear on the outputs after edge k+1.
- Collision accumulator acc[NUM_LAYERS-1:0], computed from the same-cycle eff:
  - Each cycle with startOfFrame=0: acc[i] <= acc[i] | (eff[0] & eff[i]) for i >= 1; acc[0] stays 0.
  - Cycle with startOfFrame=1:
    - collisionFlags <= acc | hits of this cycle (this cycle's overlaps are counted in the closing frame).
    - acc <= 0.
    - collisionValid <= 1 for exactly one cycle.
    - collisionFlags then holds until the next startOfFrame.
  - Disabled or transparent pixels never produce collisions; overlap is judged on eff, not raw DR.
  - startOfFrame on consecutive cycles: each pulse reports and clears. The second report contains only the hits of the second cycle.
- Reset mid-frame: the accumulator is lost, and the next startOfFrame reports only the hits since reset. The pipeline outputs BACKGROUND_COLOR until the first valid data emerges, 2 edges after reset is released.
- Width rules:
  - winLayer width is $clog2(NUM_LAYERS); when NUM_LAYERS is a power of two every code is legal.
  - No arithmetic; all comparisons are exact COLOR_W-bit equality.

Test Plan:
- Priority: DR=11'b000_0000_0110, RGB1=8'h1C, RGB2=8'hE0, all enabled -> 2 cycles later RGBOut=8'h1C, winLayer=1, winValid=1.
- Transparency and enable:
  - DR[0]=1, RGB0=8'hFF, DR[9]=1, RGB9=8'h92 -> RGBOut=8'h92, winLayer=9.
  - Same stimulus with layerEnable[9]=0 -> RGBOut=BACKGROUND_COLOR, winValid=0.
  - Same stimulus with TRANSPARENT_EN=0 -> RGBOut=8'hFF, winLayer=0.
- Collision accumulation:
  - Within one frame, assert eff[0]&eff[3] for 4 cycles and eff[0]&eff[7] for 1 cycle, then pulse startOfFrame -> next cycle collisionFlags=11'h088, collisionValid=1 for one cycle only.
  - With no overlaps in the following frame, the next startOfFrame gives collisionFlags=0.
- Same-cycle boundary: eff[0]&eff[5] only in the startOfFrame cycle -> collisionFlags bit 5 = 1; the following frame's report has bit 5 = 0 if no further overlap.
- Reset mid-operation:
  - Accumulate an overlap on layer 2, hold resetN=0 for 1 cycle, release, then startOfFrame -> collisionFlags=0.
  - RGBOut=BACKGROUND_COLOR for 2 cycles after release.
- Parameter sweep: NUM_LAYERS=4, COLOR_W=12, random DR/enable/RGB for 10k cycles -> RGBOut and winLayer match the reference priority model delayed by 2 cycles, with zero mismatches.
